// File: rtl/mealey_window_stats_pkg.sv
// Shared types for the Mealy-stream window statistics block.
// Optional MEALEY_STATS_MEAN_EN adds the mean field to each stats entry.
package Mealey_types;

    localparam int SAMPLE_W     = 9;
    localparam int WIN_LOG2_MAX = 6;
    localparam int SUM_MAX_W    = SAMPLE_W + WIN_LOG2_MAX;

    typedef logic signed [SAMPLE_W-1:0]  sample_t;
    typedef logic signed [SUM_MAX_W-1:0] sum_max_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    // Sum is stored at the widest legal size; the top narrows it.
    typedef struct packed {
        sample_t  mn;
        sample_t  mx;
        sum_max_t sum;
`ifdef MEALEY_STATS_MEAN_EN
        sample_t  mean;
`endif
    } stats_t;

    function automatic int sum_width(input int win_log2);
        return SAMPLE_W + win_log2;
    endfunction

endpackage

// File: rtl/mealey_window_stats_fifo2.sv
// Two-entry valid/ready buffer of stats entries; head is always slot 0.
// Ports: clk_i, rst_ni, push_i/data_i in, ready_i in, valid_o/head_o out,
// drop_o pulses when a push hits a full buffer with no pop.
module mealey_stats_fifo2
    import Mealey_types::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  stats_t data_i,
    input  logic   ready_i,
    output logic   valid_o,
    output stats_t head_o,
    output logic   drop_o
);

    logic [1:0] cnt_q;
    stats_t     s0_q;
    stats_t     s1_q;
    logic       pop;

    assign valid_o = (cnt_q != 2'd0);
    assign pop     = valid_o & ready_i;
    assign drop_o  = push_i & (cnt_q == 2'd2) & ~pop;
    assign head_o  = s0_q;

    // Shift organisation keeps the head a plain register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 2'd0;
            s0_q  <= '0;
            s1_q  <= '0;
        end else begin
            unique case (cnt_q)
                2'd0: begin
                    if (push_i) begin
                        s0_q  <= data_i;
                        cnt_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop) begin
                        s0_q <= data_i;
                    end else if (push_i) begin
                        s1_q  <= data_i;
                        cnt_q <= 2'd2;
                    end else if (pop) begin
                        cnt_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        s0_q <= s1_q;
                        if (push_i) begin
                            s1_q <= data_i;
                        end else begin
                            cnt_q <= 2'd1;
                        end
                    end
                end
                default: cnt_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/mealey_window_stats.sv
// Window min/max/sum(/mean) over 2^WIN_LOG2 accepted Mealy samples.
// Ports: system1000/_rstn, sample_i, en_i, clear_i, out_ready_i in;
// out_valid_o, min_o, max_o, sum_o, mean_o, overflow_o out.
// Define MEALEY_STATS_MEAN_EN to compute mean; otherwise mean_o is 0.
module mealey_window_stats
    import Mealey_types::*;
#(
    parameter int WIN_LOG2 = 3
) (
    input  logic                       system1000,
    input  logic                       system1000_rstn,
    input  logic signed [8:0]          sample_i,
    input  logic                       en_i,
    input  logic                       clear_i,
    input  logic                       out_ready_i,
    output logic                       out_valid_o,
    output logic signed [8:0]          min_o,
    output logic signed [8:0]          max_o,
    output logic signed [8+WIN_LOG2:0] sum_o,
    output logic signed [8:0]          mean_o,
    output logic                       overflow_o
);

    localparam int SW = sum_width(WIN_LOG2);
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    state_e                state_q;
    logic [WIN_LOG2-1:0]   cnt_q;
    sample_t               min_q;
    sample_t               max_q;
    logic signed [SW-1:0]  sum_q;
    logic                  ovf_q;

    sample_t               min_nx;
    sample_t               max_nx;
    logic signed [SW-1:0]  sum_nx;
    logic                  push;
    stats_t                push_data;
    stats_t                head;
    logic                  fifo_drop;
    sum_max_t              unused_head_sum;
`ifdef MEALEY_STATS_MEAN_EN
    logic signed [SW-1:0]  mean_full;
`endif

    // Result includes the sample completing the window.
    always_comb begin
        min_nx    = (sample_i < min_q) ? sample_i : min_q;
        max_nx    = (sample_i > max_q) ? sample_i : max_q;
        sum_nx    = sum_q + SW'(sample_i);
        push      = ~clear_i & en_i & (state_q == ACC)
                  & (cnt_q == CNT_LAST);
        push_data     = '0;
        push_data.mn  = min_nx;
        push_data.mx  = max_nx;
        push_data.sum = SUM_MAX_W'(sum_nx);
`ifdef MEALEY_STATS_MEAN_EN
        // Floor division; the result always fits in 9 bits.
        mean_full      = sum_nx >>> WIN_LOG2;
        push_data.mean = mean_full[8:0];
`endif
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (fifo_drop) begin
                ovf_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (en_i) begin
                        min_q   <= sample_i;
                        max_q   <= sample_i;
                        sum_q   <= SW'(sample_i);
                        cnt_q   <= WIN_LOG2'(1);
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    if (en_i) begin
                        min_q <= min_nx;
                        max_q <= max_nx;
                        sum_q <= sum_nx;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mealey_stats_fifo2 u_fifo (
        .clk_i   (system1000),
        .rst_ni  (system1000_rstn),
        .push_i  (push),
        .data_i  (push_data),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .head_o  (head),
        .drop_o  (fifo_drop)
    );

    assign min_o           = head.mn;
    assign max_o           = head.mx;
    assign sum_o           = head.sum[SW-1:0];
    assign overflow_o      = ovf_q;
    assign unused_head_sum = head.sum;
`ifdef MEALEY_STATS_MEAN_EN
    assign mean_o = head.mean;
`else
    assign mean_o = '0;
`endif

endmodule

// File: tb/tb_mealey_window_stats.sv
// Self-checking bench for mealey_window_stats at WIN_LOG2=2.
// Expected windows are queued on drive and compared on each pop.
`timescale 1ns/1ps
module tb_mealey_window_stats;

    logic              clk  = 1'b0;
    logic              rstn = 1'b1;
    logic signed [8:0] sample = '0;
    logic              en   = 1'b0;
    logic              clr  = 1'b0;
    logic              rdy  = 1'b0;
    logic              out_valid;
    logic signed [8:0] min_o;
    logic signed [8:0] max_o;
    logic signed [10:0] sum_o;
    logic signed [8:0] mean_o;
    logic              ovf;

    mealey_window_stats #(.WIN_LOG2(2)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .sample_i        (sample),
        .en_i            (en),
        .clear_i         (clr),
        .out_ready_i     (rdy),
        .out_valid_o     (out_valid),
        .min_o           (min_o),
        .max_o           (max_o),
        .sum_o           (sum_o),
        .mean_o          (mean_o),
        .overflow_o      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mn;
        int mx;
        int sm;
        int me;
    } exp_t;

    typedef struct {
        int s0;
        int s1;
        int s2;
        int s3;
        int mn;
        int mx;
        int sm;
        int me;
    } vec_t;

    exp_t q[$];
    exp_t e;
    vec_t vecs[6];
    int   ss[4];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(input int mn, input int mx,
                                input int sm, input int me);
        exp_t r;
        r.mn = mn;
        r.mx = mx;
        r.sm = sm;
`ifdef MEALEY_STATS_MEAN_EN
        r.me = me;
`else
        r.me = 0 * me;
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Scoreboard: every handshake pops one expected window.
    always @(negedge clk) begin
        if (rstn && out_valid && rdy) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual=min%0d/max%0d/sum%0d required=none",
                         min_o, max_o, sum_o);
            end else begin
                e = q.pop_front();
                if (min_o != e.mn || max_o != e.mx ||
                    sum_o != e.sm || mean_o != e.me) begin
                    failures++;
                    $display("FAIL pop_data actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                             min_o, max_o, sum_o, mean_o, e.mn, e.mx, e.sm, e.me);
                end
            end
        end
    end

    task automatic send(input int s);
        sample = 9'(s);
        en     = 1'b1;
        @(posedge clk);
        #1;
        en     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string nm, input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d required=0", nm, q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_min"}, min_o, 0);
        chk({nm, "_max"}, max_o, 0);
        chk({nm, "_sum"}, sum_o, 0);
        chk({nm, "_mean"}, mean_o, 0);
        chk({nm, "_ovf"}, ovf, 0);
    endtask

    initial begin
        vecs[0] = '{-256, -256, -256, -256, -256, -256, -1024, -256};
        vecs[1] = '{255, 255, 255, 255, 255, 255, 1020, 255};
        vecs[2] = '{-1, 0, 0, 0, -1, 0, -1, -1};
        vecs[3] = '{100, -100, 50, -51, -100, 100, -1, -1};
        vecs[4] = '{10, 20, 30, -7, -7, 30, 53, 13};
        vecs[5] = '{-3, -3, -3, -2, -3, -2, -11, -3};

        #1 rstn = 1'b0;
        #2;
        chk_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic window, then out_valid falls after the single pop.
        rdy = 1'b1;
        q.push_back(mk(-5, 7, 6, 1));
        send(3);
        send(-5);
        send(7);
        send(1);
        @(negedge clk);
        chk("basic_valid_rise", out_valid, 1);
        @(negedge clk);
        chk("basic_valid_fall", out_valid, 0);
        @(posedge clk);
        #1;

        // Table: back-to-back windows with no idle cycles.
        for (int i = 0; i < 6; i++) begin
            ss[0] = vecs[i].s0;
            ss[1] = vecs[i].s1;
            ss[2] = vecs[i].s2;
            ss[3] = vecs[i].s3;
            for (int j = 0; j < 4; j++) begin
                if (j == 3)
                    q.push_back(mk(vecs[i].mn, vecs[i].mx,
                                   vecs[i].sm, vecs[i].me));
                send(ss[j]);
            end
        end
        @(negedge clk);
        chk("table_last_valid", out_valid, 1);
        drain("table", 10);

        // Three windows with no reader: third is dropped.
        rdy = 1'b0;
        q.push_back(mk(1, 4, 10, 2));
        q.push_back(mk(5, 5, 20, 5));
        send(1); send(2); send(3); send(4);
        send(5); send(5); send(5); send(5);
        send(-8); send(-8); send(-8); send(-8);
        @(negedge clk);
        chk("ovf_set", ovf, 1);
        chk("ovf_valid", out_valid, 1);
        chk("ovf_head_min", min_o, 1);
        chk("ovf_head_sum", sum_o, 10);
        idle(3);
        @(negedge clk);
        chk("ovf_head_stable", max_o, 4);
        rdy = 1'b1;
        drain("ovf", 10);
        chk("ovf_empty", out_valid, 0);
        chk("ovf_sticky", ovf, 1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // Clear aborts partial window and beats en_i.
        send(50);
        send(60);
        sample = 9'sd99;
        en     = 1'b1;
        clr    = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
        clr = 1'b0;
        q.push_back(mk(-4, 3, -2, -1));
        send(1); send(-2); send(3); send(-4);
        drain("clear", 10);
        idle(4);
        chk("clear_single", out_valid, 0);

        // Reset mid-window with one entry buffered.
        rdy = 1'b0;
        send(7); send(7); send(7); send(7);
        idle(1);
        chk("rst_pre_valid", out_valid, 1);
        send(9);
        send(9);
        #2 rstn = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        rdy = 1'b1;
        q.push_back(mk(2, 8, 20, 5));
        send(2); send(4); send(6); send(8);
        drain("rst_fresh", 10);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
